// File: rtl/pq_cmd_scheduler.sv
// Command front-end for the bram_tree priority queue: buffers ENQUEUE/DEQUEUE/REPLACE/PEEK,
// spaces queue strobes by ISSUE_GAP, one response per command. Define PQ_SCHED_STATS_EN for counters.
module pq_cmd_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int CMD_DEPTH  = 4,
  parameter int ISSUE_GAP  = 5
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [1:0]            s_op,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  q_wrt,
  output logic                  q_read,
  output logic [DATA_WIDTH-1:0] q_data,
  input  logic                  q_full,
  input  logic                  q_empty,
  input  logic [DATA_WIDTH-1:0] q_root,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_err
`ifdef PQ_SCHED_STATS_EN
  ,
  output logic [15:0]           o_issued_cnt,
  output logic [15:0]           o_reject_cnt
`endif
);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam int CW = $clog2(ISSUE_GAP + 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(CMD_DEPTH);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(ISSUE_GAP);

  typedef enum logic [1:0] {OP_ENQ = 2'd0, OP_DEQ = 2'd1, OP_REP = 2'd2, OP_PEEK = 2'd3} op_e;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE, S_RESP} state_e;

  logic [1:0]            op_mem_q   [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [CMD_DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_d;
  logic                  s_ready_q, s_ready_d;
  logic                  fifo_empty, push, pop, legal;
  op_e                   head_op;
  logic [DATA_WIDTH-1:0] head_data;

  state_e                state_q, state_d;
  logic [CW-1:0]         gap_q, gap_d;
  logic                  resp_only_q, resp_only_d;
  logic                  q_wrt_q, q_wrt_d, q_read_q, q_read_d;
  logic [DATA_WIDTH-1:0] q_data_q, q_data_d;
  logic                  r_valid_q, r_valid_d, r_err_q, r_err_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign push       = s_valid && s_ready_q;
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign head_op    = op_e'(op_mem_q[rd_ptr_q[AW-1:0]]);
  assign head_data  = data_mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d  = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d  = rd_ptr_q + (AW+1)'(pop);
    count_d   = wr_ptr_d - rd_ptr_d;
    s_ready_d = (count_d != DEPTH_CNT);
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      op_mem_q[wr_ptr_q[AW-1:0]]   <= s_op;
      data_mem_q[wr_ptr_q[AW-1:0]] <= s_data;
    end
  end

  always_comb begin
    legal       = (head_op == OP_ENQ) ? !q_full : !q_empty;
    state_d     = state_q;
    gap_d       = gap_q;
    resp_only_d = resp_only_q;
    q_wrt_d     = 1'b0;
    q_read_d    = 1'b0;
    q_data_d    = '0;
    r_valid_d   = r_valid_q;
    r_data_d    = r_data_q;
    r_err_d     = r_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d     = S_ISSUE;
          resp_only_d = 1'b1;
          r_err_d     = !legal;
          r_data_d    = '0;
          if (legal) begin
            unique case (head_op)
              OP_ENQ: begin
                q_wrt_d     = 1'b1;
                q_data_d    = head_data;
                resp_only_d = 1'b0;
              end
              OP_DEQ: begin
                q_read_d    = 1'b1;
                r_data_d    = q_root;
                resp_only_d = 1'b0;
              end
              OP_REP: begin
                q_wrt_d     = 1'b1;
                q_read_d    = 1'b1;
                q_data_d    = head_data;
                r_data_d    = q_root;
                resp_only_d = 1'b0;
              end
              default: r_data_d = q_root;
            endcase
          end
        end
      end
      // PEEK and rejected commands use the ISSUE slot strobe-free so their response lands one edge later.
      S_ISSUE: begin
        if (resp_only_q) begin
          state_d   = S_RESP;
          r_valid_d = 1'b1;
        end else begin
          state_d = S_SETTLE;
          gap_d   = GAP_LOAD;
        end
      end
      S_SETTLE: begin
        gap_d = gap_q - CW'(1);
        if (gap_q <= CW'(1)) begin
          state_d   = S_RESP;
          r_valid_d = 1'b1;
        end
      end
      default: begin
        if (r_ready) begin
          state_d   = S_IDLE;
          r_valid_d = 1'b0;
        end
      end
    endcase
  end

`ifdef PQ_SCHED_STATS_EN
  logic [15:0] issued_q, issued_d, reject_q, reject_d;
  always_comb begin
    issued_d = issued_q;
    reject_d = reject_q;
    if ((q_wrt_d || q_read_d) && issued_q != 16'hFFFF) issued_d = issued_q + 16'd1;
    if (pop && !legal && reject_q != 16'hFFFF)         reject_d = reject_q + 16'd1;
  end
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      issued_q <= '0;
      reject_q <= '0;
    end else begin
      issued_q <= issued_d;
      reject_q <= reject_d;
    end
  end
  assign o_issued_cnt = issued_q;
  assign o_reject_cnt = reject_q;
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      s_ready_q   <= 1'b0;
      state_q     <= S_IDLE;
      gap_q       <= '0;
      resp_only_q <= 1'b0;
      q_wrt_q     <= 1'b0;
      q_read_q    <= 1'b0;
      q_data_q    <= '0;
      r_valid_q   <= 1'b0;
      r_data_q    <= '0;
      r_err_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      s_ready_q   <= s_ready_d;
      state_q     <= state_d;
      gap_q       <= gap_d;
      resp_only_q <= resp_only_d;
      q_wrt_q     <= q_wrt_d;
      q_read_q    <= q_read_d;
      q_data_q    <= q_data_d;
      r_valid_q   <= r_valid_d;
      r_data_q    <= r_data_d;
      r_err_q     <= r_err_d;
    end
  end

  assign s_ready = s_ready_q;
  assign q_wrt   = q_wrt_q;
  assign q_read  = q_read_q;
  assign q_data  = q_data_q;
  assign r_valid = r_valid_q;
  assign r_data  = r_data_q;
  assign r_err   = r_err_q;
endmodule

// File: tb/tb_pq_cmd_scheduler.sv
// Bench for pq_cmd_scheduler: directed timing steps plus a randomized run against a
// behavioural priority-queue model and an in-order command reference.
module tb_pq_cmd_scheduler;
  localparam int DW    = 16;
  localparam int CAP   = 4;
  localparam int NRAND = 80;

  logic          CLK = 1'b0, RSTn = 1'b0, s_valid = 1'b0, r_ready = 1'b0;
  logic [1:0]    s_op = 2'd0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, q_wrt, q_read, r_valid, r_err;
  logic [DW-1:0] q_data, r_data;
  logic          q_full, q_empty;
  logic [DW-1:0] q_root;

  logic          use_model = 1'b0;
  logic          dir_full = 1'b0, dir_empty = 1'b1;
  logic [DW-1:0] dir_root = '0;
  logic          m_full = 1'b0, m_empty = 1'b1;
  logic [DW-1:0] m_root = '0;

  assign q_full  = use_model ? m_full  : dir_full;
  assign q_empty = use_model ? m_empty : dir_empty;
  assign q_root  = use_model ? m_root  : dir_root;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] rq[$];
  logic [DW+1:0] exp_strobes[$];
  logic [DW:0]   exp_resp[$];

`ifdef PQ_SCHED_STATS_EN
  logic [15:0] issued_cnt, reject_cnt;
`endif

  pq_cmd_scheduler #(.DATA_WIDTH(DW), .CMD_DEPTH(4), .ISSUE_GAP(5)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .s_valid(s_valid), .s_ready(s_ready), .s_op(s_op), .s_data(s_data),
    .q_wrt(q_wrt), .q_read(q_read), .q_data(q_data),
    .q_full(q_full), .q_empty(q_empty), .q_root(q_root),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_err(r_err)
`ifdef PQ_SCHED_STATS_EN
    , .o_issued_cnt(issued_cnt), .o_reject_cnt(reject_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic int max_idx(input logic [DW-1:0] q[$]);
    int mi = -1;
    for (int i = 0; i < q.size(); i++)
      if (mi < 0 || q[i] > q[mi]) mi = i;
    return mi;
  endfunction

  // Behavioural queue: reacts to strobes, sampled mid-cycle.
  always @(negedge CLK) begin
    if (use_model && RSTn) begin
      if (q_wrt || q_read) begin
        if (exp_strobes.size() == 0) chk("strobe_extra", 32'({q_wrt, q_read}), 32'd0);
        else chk("strobe_kind", 32'({q_wrt, q_read, q_data}), 32'(exp_strobes.pop_front()));
        if (q_read && mq.size() > 0) mq.delete(max_idx(mq));
        if (q_wrt) mq.push_back(q_data);
      end
      m_full  <= (mq.size() >= CAP);
      m_empty <= (mq.size() == 0);
      m_root  <= (mq.size() != 0) ? mq[max_idx(mq)] : '0;
    end
  end

  // Reference: commands take effect strictly in acceptance order.
  task automatic ref_cmd(input logic [1:0] op, input logic [DW-1:0] d);
    int          mi;
    logic [DW:0] resp;
    mi   = max_idx(rq);
    resp = {1'b1, {DW{1'b0}}};
    case (op)
      2'd0: if (rq.size() < CAP) begin
        resp = '0;
        rq.push_back(d);
        exp_strobes.push_back({2'b10, d});
      end
      2'd1: if (mi >= 0) begin
        resp = {1'b0, rq[mi]};
        rq.delete(mi);
        exp_strobes.push_back({2'b01, {DW{1'b0}}});
      end
      2'd2: if (mi >= 0) begin
        resp = {1'b0, rq[mi]};
        rq.delete(mi);
        rq.push_back(d);
        exp_strobes.push_back({2'b11, d});
      end
      default: if (mi >= 0) resp = {1'b0, rq[mi]};
    endcase
    exp_resp.push_back(resp);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [DW-1:0] d);
    int w = 0;
    s_valid = 1'b1;
    s_op    = op;
    s_data  = d;
    while (!s_ready && w < 50) begin
      step();
      w++;
    end
    if (!s_ready) chk("send_timeout", 32'(s_ready), 32'd1);
    step();
    s_valid = 1'b0;
  endtask

  task automatic consume();
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    chk("resp_drop", 32'(r_valid), 32'd0);
  endtask

  initial begin
    logic [1:0]    bp_op   [6];
    logic [DW-1:0] bp_data [6];
    logic [DW:0]   bp_exp  [6];
    int sent, got, strobes, cyc;
    logic acc;
`ifdef PQ_SCHED_STATS_EN
    logic [15:0] rej0, iss0;
`endif

    // Reset and s_ready release
    step(); step();
    chk("reset_ctrl", 32'({s_ready, q_wrt, q_read, r_valid, r_err}), 32'd0);
    chk("reset_q_data", 32'(q_data), 32'd0);
    chk("reset_r_data", 32'(r_data), 32'd0);
    RSTn = 1'b1;
    #1 chk("s_ready_before_edge", 32'(s_ready), 32'd0);
    step();
    chk("s_ready_after_edge", 32'(s_ready), 32'd1);

    // ENQUEUE 300 on an empty queue
    send_cmd(2'd0, 16'd300);
    chk("enq_no_early_strobe", 32'(q_wrt), 32'd0);
    step();
    chk("enq_strobe", 32'({q_wrt, q_read}), 32'd2);
    chk("enq_q_data", 32'(q_data), 32'd300);
    step();
    chk("enq_strobe_drop", 32'({q_wrt, q_read}), 32'd0);
    chk("enq_q_data_zero", 32'(q_data), 32'd0);
    for (int k = 3; k <= 7; k++) begin
      step();
      chk("enq_rvalid_timing", 32'(r_valid), 32'(k == 7));
    end
    chk("enq_resp", 32'({r_err, r_data}), 32'd0);
    consume();

    // DEQUEUE on an empty queue is rejected
    send_cmd(2'd1, 16'd0);
    step();
    chk("deq_empty_no_strobe", 32'({q_wrt, q_read, r_valid}), 32'd0);
    step();
    chk("deq_empty_rvalid", 32'(r_valid), 32'd1);
    chk("deq_empty_resp", 32'({r_err, r_data}), 32'h10000);
    consume();

    // REPLACE 15 with root 900
    dir_empty = 1'b0;
    dir_root  = 16'd900;
    send_cmd(2'd2, 16'd15);
    step();
    chk("rep_strobe", 32'({q_wrt, q_read, q_data}), 32'({2'b11, 16'd15}));
    step();
    chk("rep_strobe_drop", 32'({q_wrt, q_read, q_data}), 32'd0);
    for (int k = 3; k <= 7; k++) begin
      step();
      chk("rep_rvalid_timing", 32'(r_valid), 32'(k == 7));
    end
    chk("rep_resp", 32'({r_err, r_data}), 32'd900);
    consume();

    // PEEK returns root without a strobe
    send_cmd(2'd3, 16'd5);
    step();
    chk("peek_no_strobe", 32'({q_wrt, q_read, r_valid}), 32'd0);
    step();
    chk("peek_resp", 32'({r_valid, r_err, r_data}), 32'({2'b10, 16'd900}));
    consume();

    // ENQUEUE while full is rejected
    dir_full = 1'b1;
`ifdef PQ_SCHED_STATS_EN
    rej0 = reject_cnt;
    iss0 = issued_cnt;
`endif
    send_cmd(2'd0, 16'd44);
    step();
    chk("enq_full_no_strobe", 32'({q_wrt, q_read}), 32'd0);
    step();
    chk("enq_full_resp", 32'({r_valid, r_err, r_data}), 32'({2'b11, 16'd0}));
`ifdef PQ_SCHED_STATS_EN
    chk("stats_reject_inc", 32'(reject_cnt), 32'(rej0 + 16'd1));
    chk("stats_issued_same", 32'(issued_cnt), 32'(iss0));
`endif
    consume();

    // Backpressure: six back-to-back commands with r_ready held low
    bp_op   = '{2'd1, 2'd0, 2'd3, 2'd1, 2'd0, 2'd3};
    bp_data = '{16'd0, 16'd11, 16'd0, 16'd0, 16'd22, 16'd0};
    bp_exp  = '{17'd500, 17'h10000, 17'd500, 17'd500, 17'h10000, 17'd500};
    dir_root = 16'd500;
    sent = 0; got = 0; strobes = 0; cyc = 0;
    while (cyc < 230 && !(got == 6 && sent == 6)) begin
      r_ready = (cyc >= 30);
      s_valid = (sent < 6);
      s_op    = bp_op[sent % 6];
      s_data  = bp_data[sent % 6];
      @(negedge CLK);
      acc = s_valid && s_ready;
      if (q_wrt || q_read) strobes++;
      if (r_valid && r_ready) begin
        chk("bp_resp_order", 32'({r_err, r_data}), 32'(bp_exp[got % 6]));
        got++;
      end
      @(posedge CLK);
      #1;
      if (acc) sent++;
      cyc++;
      if (cyc == 30) begin
        chk("bp_accepted_stalled", 32'(sent), 32'd5);
        chk("bp_one_strobe", 32'(strobes), 32'd1);
        chk("bp_s_ready_low", 32'(s_ready), 32'd0);
        chk("bp_first_resp", 32'({r_valid, r_err, r_data}), 32'({2'b10, 16'd500}));
      end
    end
    s_valid = 1'b0;
    r_ready = 1'b0;
    chk("bp_resp_count", 32'(got), 32'd6);
    chk("bp_total_strobes", 32'(strobes), 32'd2);

    // Reset asserted during SETTLE
    dir_full  = 1'b0;
    dir_empty = 1'b1;
    send_cmd(2'd0, 16'd77);
    step();
    chk("rst_pre_strobe", 32'(q_wrt), 32'd1);
    step(); step();
    #2 RSTn = 1'b0;
    #1;
    chk("rst_async_ctrl", 32'({s_ready, q_wrt, q_read, r_valid, r_err}), 32'd0);
    chk("rst_async_data", 32'({q_data, r_data}), 32'd0);
    step();
    RSTn = 1'b1;
    r_ready = 1'b1;
    strobes = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (r_valid || q_wrt || q_read) strobes++;
    end
    r_ready = 1'b0;
    chk("rst_no_activity", 32'(strobes), 32'd0);
    chk("rst_s_ready_back", 32'(s_ready), 32'd1);

    // Randomized traffic against the behavioural queue and reference
    use_model = 1'b1;
    mq.delete(); rq.delete(); exp_strobes.delete(); exp_resp.delete();
    RSTn = 1'b0;
    step(); step();
    RSTn = 1'b1;
    step();
    fork
      begin : producer
        int w, idle, pct;
        logic a;
        for (int n = 0; n < NRAND; n++) begin
          idle = $urandom_range(0, 3);
          repeat (idle) step();
          pct     = $urandom_range(0, 99);
          s_op    = (pct < 40) ? 2'd0 : (pct < 60) ? 2'd1 : (pct < 80) ? 2'd2 : 2'd3;
          s_data  = DW'($urandom_range(0, 65535));
          s_valid = 1'b1;
          a = 1'b0;
          w = 0;
          while (!a && w < 2000) begin
            @(negedge CLK);
            if (s_ready) begin
              a = 1'b1;
              ref_cmd(s_op, s_data);
            end
            @(posedge CLK);
            #1;
            w++;
          end
          s_valid = 1'b0;
          if (!a) chk("rand_accept_timeout", 32'(s_ready), 32'd1);
        end
      end
      begin : consumer
        int rgot, rcyc;
        rgot = 0;
        rcyc = 0;
        while (rgot < NRAND && rcyc < 20000) begin
          r_ready = ($urandom_range(0, 3) != 0);
          @(negedge CLK);
          if (r_valid && r_ready) begin
            if (exp_resp.size() == 0) chk("resp_extra", 32'(r_valid), 32'd0);
            else chk("rand_resp", 32'({r_err, r_data}), 32'(exp_resp.pop_front()));
            rgot++;
          end
          @(posedge CLK);
          #1;
          rcyc++;
        end
        r_ready = 1'b0;
        chk("rand_resp_count", 32'(rgot), NRAND);
      end
    join
    repeat (3) step();
    chk("rand_strobes_left", 32'(exp_strobes.size()), 32'd0);
    chk("rand_queue_size", 32'(mq.size()), 32'(rq.size()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pq_cmd_scheduler.md
# pq_cmd_scheduler

- Command front-end that sits directly upstream of the `bram_tree` priority queue.
- Accepts ENQUEUE/DEQUEUE/REPLACE/PEEK commands over a valid/ready stream and buffers them in a small FIFO.
- Issues each command to the queue as a one-cycle strobe, spaced so the heap can settle, and rejects illegal operations (full/empty).
- Returns exactly one response per command over a second valid/ready stream.

## Interface
Parameters:
- DATA_WIDTH, 16, key width; matches the queue's DATA_WIDTH.
- CMD_DEPTH, 4, command FIFO entries (power of two, ≥2).
- ISSUE_GAP, 5, settle cycles after each strobe (≥1).

Ports:
- CLK  in  1  clock; single clock domain.
- RSTn  in  1  asynchronous active-low reset.
- s_valid  in  1  command valid.
- s_ready  out  1  command accepted when s_valid&&s_ready at CLK rise.
- s_op  in  2  0=ENQUEUE, 1=DEQUEUE, 2=REPLACE, 3=PEEK.
- s_data  in  DATA_WIDTH  key for ENQUEUE/REPLACE; ignored otherwise.
- q_wrt  out  1  to queue i_wrt.
- q_read  out  1  to queue i_read.
- q_data  out  DATA_WIDTH  to queue i_data.
- q_full  in  1  from queue o_full.
- q_empty  in  1  from queue o_empty.
- q_root  in  DATA_WIDTH  from queue o_data (current max).
- r_valid  out  1  response valid.
- r_ready  in  1  response consumed when r_valid&&r_ready.
- r_data  out  DATA_WIDTH  response key.
- r_err  out  1  command rejected.

## Operation
- **Command FIFO:** CMD_DEPTH entries of {op, data}, wrap-around pointers with an extra wrap bit.
  - s_ready is registered and equals FIFO not-full; reset value 0, rises the first edge after reset release.
  - Simultaneous push and pop on a full FIFO is allowed; s_ready stays 1 that cycle.
- **FSM states:** IDLE, ISSUE, SETTLE, RESP.
- **IDLE:** when the FIFO is non-empty, decide on the head using the q_full, q_empty and q_root values of that cycle; pop the head at the same edge.
  - ENQUEUE with q_full=0 → ISSUE with q_wrt=1, q_read=0.
  - DEQUEUE with q_empty=0 → ISSUE with q_wrt=0, q_read=1.
  - REPLACE with q_empty=0 → ISSUE with q_wrt=1, q_read=1.
  - PEEK with q_empty=0 → RESP directly; no strobe issued.
  - Rejected (ENQUEUE when full; DEQUEUE, REPLACE or PEEK when empty) → RESP directly; no strobe; r_err=1, r_data=0.
- **ISSUE:** lasts exactly one cycle; q_wrt/q_read/q_data are registered and high only in this cycle; then → SETTLE.
- **SETTLE:** down-counter loaded with ISSUE_GAP; → RESP when it reaches 0. No queue strobes are driven.
- **RESP:** r_valid=1 and r_data/r_err held stable until r_ready; → IDLE at the handshake edge.
  - At most one response is outstanding; the FIFO keeps accepting commands while RESP stalls.
- **Response data:**
  - DEQUEUE, REPLACE, PEEK: q_root captured at the IDLE decision edge, i.e. the pre-op maximum.
  - ENQUEUE: r_data=0, r_err=0.
- q_data outputs 0 whenever q_wrt=0.

## Timing
- **Reset values:** s_ready, q_wrt, q_read, q_data, r_valid, r_data and r_err are all 0; FIFO empty; state IDLE.
  - Reset asserted mid-operation: strobes drop immediately, and the pending command and response are discarded.
- **Latency** (acceptance edge = E0):
  - FIFO head is visible after E0; IDLE decides at E1.
  - Strobe is high from E1 to E2.
  - Legal ENQUEUE/DEQUEUE/REPLACE: r_valid rises at E(2+ISSUE_GAP), i.e. E7 by default.
  - PEEK and rejected commands: r_valid rises at E2.
- **Throughput:** the RESP→IDLE handshake edge costs one IDLE cycle before the next decision. Minimum issue spacing is ISSUE_GAP+3 cycles with r_ready held at 1.
- **Stall:** r_ready=0 blocks only the FSM.
- **Arithmetic:** gap counter width is $clog2(ISSUE_GAP+1); FIFO count never exceeds CMD_DEPTH.

## Configuration
- PQ_SCHED_STATS_EN defined: adds outputs o_issued_cnt (16 bits, counts strobes) and o_reject_cnt (16 bits, counts r_err responses). Both saturate at 16'hFFFF and reset to 0.
- PQ_SCHED_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- **Reset then ENQUEUE 300:**
  - s_ready goes 1 one edge after RSTn rises.
  - q_wrt is high for exactly one cycle, 1 edge after acceptance, with q_data=300.
  - r_valid appears 7 edges after acceptance with r_data=0, r_err=0.
- **DEQUEUE while q_empty=1:** no strobe; r_valid rises 2 edges after acceptance with r_err=1, r_data=0.
- **With q_root=900, q_empty=0, send REPLACE 15:**
  - q_wrt=q_read=1 for one cycle, q_data=15.
  - Response r_data=900, r_err=0.
- **Backpressure:**
  - Hold r_ready=0 and send 6 commands back-to-back: s_ready drops after the FIFO fills (4 buffered plus 1 in flight); no second strobe until the first response is consumed.
  - Release r_ready: all 6 responses arrive in order.
- **ENQUEUE with q_full=1:** rejected with r_err=1 and no q_wrt. With PQ_SCHED_STATS_EN defined, o_reject_cnt increments by 1.
- **Reset mid-SETTLE:** assert RSTn=0 during SETTLE; all outputs are 0 immediately and no response is produced after release.
